// File: rtl/friscv_scoreboard.sv
// Register-hazard scoreboard sitting between issue and the register file.
// Each of x1..x31 has a counter of ALU writes that are still in flight. Issue
// stalls on a pending source or a saturated destination counter, and
// completions are snooped from the ALU write port into the register file.
module friscv_scoreboard #(
  parameter int unsigned CNT_W = 2
) (
  input  logic             aclk,
  input  logic             aresetn,
  input  logic             srst,
  input  logic             issue_valid,
  output logic             issue_ready,
  input  logic [4:0]       issue_rs1_addr,
  input  logic [4:0]       issue_rs2_addr,
  input  logic             issue_rd_wr,
  input  logic [4:0]       issue_rd_addr,
  input  logic             alu_rd_wr,
  input  logic [4:0]       alu_rd_addr,
  output logic             hazard_rs1,
  output logic             hazard_rs2,
  output logic             hazard_rd,
  output logic [31:0]      busy,
  output logic [CNT_W+4:0] pending,
  output logic             err_underflow
);

  localparam logic [CNT_W-1:0] CntMax = '1;

  logic [CNT_W-1:0] cnt_q [31:1];
  logic [CNT_W-1:0] cnt_d [31:1];
  logic [CNT_W+4:0] pending_q, pending_d;
  logic             err_q, err_d;
  logic [31:0]      sat;

  logic accept, inc, dec, same_reg, inc_eff, dec_eff, underflow;

  // Per-register busy and saturated flags; x0 never tracked.
  always_comb begin
    busy    = '0;
    sat     = '0;
    for (int i = 1; i < 32; i++) begin
      busy[i] = (cnt_q[i] != '0);
      sat[i]  = (cnt_q[i] == CntMax);
    end
  end

  assign hazard_rs1  = busy[issue_rs1_addr];
  assign hazard_rs2  = busy[issue_rs2_addr];
  assign hazard_rd   = issue_rd_wr & sat[issue_rd_addr];
  assign issue_ready = ~(hazard_rs1 | hazard_rs2 | hazard_rd);

  assign accept    = issue_valid & issue_ready;
  assign inc       = accept & issue_rd_wr & (issue_rd_addr != 5'd0);
  assign dec       = alu_rd_wr & (alu_rd_addr != 5'd0);
  // Issue and completion to the same register cancel, even from an empty counter.
  assign same_reg  = inc & dec & (issue_rd_addr == alu_rd_addr);
  assign inc_eff   = inc & ~same_reg;
  assign dec_eff   = dec & ~same_reg & busy[alu_rd_addr];
  assign underflow = dec & ~same_reg & ~busy[alu_rd_addr];

  // Next-state counters, pending total and sticky underflow flag.
  always_comb begin
    for (int i = 1; i < 32; i++) begin
      cnt_d[i] = cnt_q[i];
      if (inc_eff && issue_rd_addr == 5'(i)) cnt_d[i] = cnt_q[i] + 1'b1;
      if (dec_eff && alu_rd_addr == 5'(i))   cnt_d[i] = cnt_q[i] - 1'b1;
    end
    pending_d = pending_q;
    if (inc_eff && !dec_eff)      pending_d = pending_q + 1'b1;
    else if (dec_eff && !inc_eff) pending_d = pending_q - 1'b1;
    err_d = err_q | underflow;
  end

  // State registers: async reset, then synchronous reset with priority.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      for (int i = 1; i < 32; i++) cnt_q[i] <= '0;
      pending_q <= '0;
      err_q     <= 1'b0;
    end else if (srst) begin
      for (int i = 1; i < 32; i++) cnt_q[i] <= '0;
      pending_q <= '0;
      err_q     <= 1'b0;
    end else begin
      for (int i = 1; i < 32; i++) cnt_q[i] <= cnt_d[i];
      pending_q <= pending_d;
      err_q     <= err_d;
    end
  end

  assign pending       = pending_q;
  assign err_underflow = err_q;

endmodule
